serial_adder: RTL and testbench

Bit-serial ripple adder built around the team's single-bit full-adder cell: one full-adder evaluation per clock, LSB first, with the carry held in a flip-flop between cycles. It adds two WIDTH-bit operands plus carry-in over WIDTH cycles and presents the registered sum and carry-out. It is used where area matters more than latency, upstream of result consumers that wait on a `done` pulse.

---
 rtl/serial_adder.sv | 157 +++++++++++++++
 tb/tb_serial_adder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder, one full-adder step per clock, LSB first.
// Adds two WIDTH-bit operands plus carry-in over WIDTH RUN cycles.
// The sum and carry-out are registered and held until the next completion.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the o_ovf port, which gives
// two's-complement overflow of the last completed addition.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for i_start; operands and carry-in captured on accept
// S_RUN  | one full-adder bit per cycle, WIDTH cycles
// S_DONE | result registered, o_done pulses for this single cycle

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             o_ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_load;
    logic             w_last;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic             r_c;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_res_nxt;

    // Full-adder cell on the current LSBs and the held carry.
    assign w_s = r_sa[0] ^ r_sb[0] ^ r_c;
    assign w_c = (r_sa[0] & r_sb[0]) | (r_c & (r_sa[0] ^ r_sb[0]));

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    assign w_res_nxt = (r_res >> 1) | {w_s, {(WIDTH-1){1'b0}}};

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and state-derived outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_last      = 1'b0;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, carry flop, bit counter and partial result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_res <= '0;
        end else if (w_load) begin
            r_sa  <= i_a;
            r_sb  <= i_b;
            r_c   <= i_cin;
            r_cnt <= '0;
            r_res <= '0;
        end else if (r_state == S_RUN) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_c   <= w_c;
            r_cnt <= r_cnt + CW'(1);
            r_res <= w_res_nxt;
        end
    end

    // Result registers update only on the final bit so partial sums stay hidden.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= w_res_nxt;
            r_cout <= w_c;
        end
    end

    assign o_sum  = r_sum;
    assign o_cout = r_cout;

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the final bit r_c is the carry into the MSB and w_c the carry out of it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_c ^ w_c;
        end
    end

    assign o_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder (WIDTH=8): directed and random operations checked
// against an arithmetic reference of a+b+cin.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_ovf  = 1'b0;

    serial_adder #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_cin   (cin),
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .o_ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain unsigned and signed arithmetic on the operands.
    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc);
        logic [W:0] t;
        int         s;
        t = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
        exp_sum  = t[W-1:0];
        exp_cout = t[W];
        s = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
        exp_ovf  = (s > (2**(W-1)) - 1) || (s < -(2**(W-1)));
    endtask

    task automatic check_result(input string tag);
        chk({tag, "_sum"}, 64'(sum), 64'(exp_sum));
        chk({tag, "_cout"}, 64'(cout), 64'(exp_cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk({tag, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`endif
    endtask

    // One full operation; poke>0 re-pulses start with junk operands after edge poke.
    task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic oc, input int poke);
        int lat;
        bit got;
        @(negedge clk);
        start = 1'b1; a = oa; b = ob; cin = oc;
        @(negedge clk);
        start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
        chk({tag, "_busy_accept"}, 64'(busy), 64'd1);
        lat = 0;
        got = 1'b0;
        for (int i = 1; i <= W + 4 && !got; i++) begin
            @(negedge clk);
            lat = i;
            start = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1;
            end else begin
                chk({tag, "_sum_hold"}, 64'(sum), 64'(exp_sum));
                if (i == poke) begin
                    start = 1'b1; a = '1; b = '1; cin = 1'b1;
                end
            end
        end
        chk({tag, "_latency"}, 64'(lat), 64'(W));
        model(oa, ob, oc);
        check_result(tag);
        chk({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        chk({tag, "_done_width"}, 64'(done), 64'd0);
        chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int last_done;
        int n_done;
        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_done", 64'(done), 64'd0);
            check_result("idle");
        end

        // Directed vectors.
        run_op("ff_01", 8'hFF, 8'h01, 1'b0, 0);
        run_op("5a_a5_c1", 8'h5A, 8'hA5, 1'b1, 0);
        run_op("5a_a5_c0", 8'h5A, 8'hA5, 1'b0, 0);
        run_op("7f_01", 8'h7F, 8'h01, 1'b0, 0);
        run_op("80_80", 8'h80, 8'h80, 1'b0, 0);
        run_op("00_00", 8'h00, 8'h00, 1'b0, 0);
        run_op("ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 0);
        run_op("80_ff", 8'h80, 8'hFF, 1'b0, 0);

        // Start during RUN is ignored.
        run_op("ignore_start", 8'h10, 8'h20, 1'b0, 3);

        // Reset mid-RUN aborts with no done and clears outputs.
        @(negedge clk);
        start = 1'b1; a = 8'h33; b = 8'h44; cin = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_sum = '0; exp_cout = 1'b0; exp_ovf = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        check_result("rst");
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("rst_no_done", 64'(done), 64'd0);
            chk("rst_no_busy", 64'(busy), 64'd0);
        end
        run_op("after_rst", 8'h12, 8'h34, 1'b1, 0);

        // Start held high: back-to-back operations every W+2 cycles.
        @(negedge clk);
        start = 1'b1; a = 8'hC3; b = 8'h5E; cin = 1'b1;
        model(8'hC3, 8'h5E, 1'b1);
        last_done = -1;
        n_done = 0;
        for (int i = 0; i < 5 * (W + 2); i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n_done++;
                check_result("b2b");
                if (last_done >= 0) chk("b2b_period", 64'(i - last_done), 64'(W + 2));
                last_done = i;
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(n_done), 64'd5);
        repeat (W + 3) @(negedge clk);

        // Random operations.
        for (int k = 0; k < 300; k++) begin
            run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
